// File: rtl/varwidth_fifo_pkg.sv
// Shared constants, FSM encoding and byte accounting for the variable-width capture FIFO.
package varwidth_fifo_pkg;

   localparam int unsigned SAMPLE_W = 10;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned ACC_W    = 18;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned BYTES_W  = 36;

   typedef enum logic [1:0] {
      StIdle,
      StWaitDone,
      StDrain,
      StFinish
   } state_e;

   // Bytes occupied by n packed samples; wide enough that n*10 cannot wrap.
   function automatic logic [BYTES_W-1:0] bytes_for_samples(input logic [31:0] n);
      logic [BYTES_W-1:0] bits;
      bits = {4'b0000, n} * 36'd10;
      return (bits + 36'd7) >> 3;
   endfunction

endpackage

// File: rtl/varwidth_bit_unpacker.sv
// Byte-to-sample unpacker: shift accumulator, bit count, and a valid/ready output register.
module varwidth_bit_unpacker
   import varwidth_fifo_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                byte_valid,
   input  logic [BYTE_W-1:0]   byte_data,
   input  logic                extract_en,
   input  logic                sample_ready,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_valid,
   output logic                has_sample,
   output logic                extract
);

   logic [ACC_W-1:0]    acc_q, acc_d, acc_in, aligned;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_in;
   logic [SAMPLE_W-1:0] data_q, data_d;
   logic                valid_q, valid_d, slot_free;

   always_comb begin
      acc_in = acc_q;
      cnt_in = cnt_q;
      if (byte_valid) begin
         acc_in = {acc_q[ACC_W-BYTE_W-1:0], byte_data};
         cnt_in = cnt_q + CNT_W'(BYTE_W);
      end
      slot_free = !valid_q || sample_ready;
      extract   = extract_en && slot_free && (cnt_in >= CNT_W'(SAMPLE_W));
      // Oldest complete sample sits just above the (cnt_in - 10) freshest bits.
      aligned   = acc_in >> (cnt_in - CNT_W'(SAMPLE_W));
      acc_d     = acc_in;
      cnt_d     = extract ? cnt_in - CNT_W'(SAMPLE_W) : cnt_in;
      data_d    = extract ? aligned[SAMPLE_W-1:0] : data_q;
      valid_d   = extract ? 1'b1 : (valid_q && !sample_ready);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign has_sample   = (cnt_q >= CNT_W'(SAMPLE_W));

endmodule

// File: rtl/varwidth_fifo_reader.sv
// Drains packed 10-bit samples from the capture FIFO once capture completes and streams them
// out on valid/ready; flags underrun when the FIFO runs dry early.
module varwidth_fifo_reader #(
   parameter int unsigned SAMPLE_W = 10,
   parameter int unsigned NSAMP_W  = 32
) (
   input  logic                rd_clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NSAMP_W-1:0]  number_samples,
   input  logic                fifo_done,
   input  logic                fifo_empty,
   output logic                fifo_rd_ce,
   input  logic [7:0]          fifo_rd_data,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                busy,
   output logic                done,
   output logic                underrun
);
   import varwidth_fifo_pkg::*;

   state_e               state_q, state_d;
   logic [NSAMP_W-1:0]   samples_left_q, samples_left_d;
   logic [BYTES_W-1:0]   bytes_left_q, bytes_left_d;
   logic                 inflight_q, underrun_q, underrun_d;
   logic                 rd_ce, clear, extract_en, extract, has_sample, slot_clear;

   assign extract_en = (state_q == StDrain) && (samples_left_q != '0);
   assign slot_clear = !sample_valid || sample_ready;

   varwidth_bit_unpacker u_unpacker (
      .clk          (rd_clk),
      .rst          (rst),
      .clear        (clear),
      .byte_valid   (inflight_q),
      .byte_data    (fifo_rd_data),
      .extract_en   (extract_en),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .has_sample   (has_sample),
      .extract      (extract)
   );

   always_comb begin
      state_d        = state_q;
      samples_left_d = samples_left_q;
      bytes_left_d   = bytes_left_q;
      underrun_d     = underrun_q;
      rd_ce          = 1'b0;
      clear          = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               clear          = 1'b1;
               underrun_d     = 1'b0;
               samples_left_d = number_samples;
               bytes_left_d   = bytes_for_samples(32'(number_samples));
               state_d        = (number_samples == '0) ? StFinish : StWaitDone;
            end
         end
         StWaitDone: begin
            if (fifo_done) state_d = StDrain;
         end
         StDrain: begin
            rd_ce = !inflight_q && !has_sample && (bytes_left_q != '0) && !fifo_empty
                    && !underrun_q;
            if (rd_ce) bytes_left_d = bytes_left_q - 1'b1;
            if (extract) samples_left_d = samples_left_q - 1'b1;
            if (!underrun_q && !inflight_q && fifo_empty && (bytes_left_q != '0)) begin
               underrun_d = 1'b1;
            end
            // After underrun, leave once no complete sample remains and the output has drained.
            if (slot_clear && (samples_left_q == '0)) begin
               state_d = StFinish;
            end else if (slot_clear && underrun_q && !inflight_q && !has_sample) begin
               state_d = StFinish;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state_q        <= StIdle;
         samples_left_q <= '0;
         bytes_left_q   <= '0;
         inflight_q     <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         samples_left_q <= samples_left_d;
         bytes_left_q   <= bytes_left_d;
         inflight_q     <= rd_ce;
         underrun_q     <= underrun_d;
      end
   end

   assign fifo_rd_ce = rd_ce;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFinish);
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_varwidth_fifo_reader.sv
// Directed bench for varwidth_fifo_reader: FIFO model, bit-stream sample model, stream monitor.
module tb_varwidth_fifo_reader;

   logic        clk = 1'b0;
   logic        rst, start, fifo_done, fifo_empty, fifo_rd_ce;
   logic [31:0] number_samples;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic [9:0]  sample_data;
   logic        sample_valid, sample_ready, busy, done, underrun;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [7:0]  fifo_mem [0:255];
   int          fifo_len = 0;
   int          rd_ptr = 0;
   int          rd_ce_count = 0;
   int          ready_mode = 0;
   int          rcyc = 0;
   int          accepted = 0;
   logic [9:0]  cap [0:15];
   logic [9:0]  exp_q [$];
   bit          prev_stall = 0;
   logic [9:0]  prev_data = '0;

   varwidth_fifo_reader dut (
      .rd_clk         (clk),
      .rst            (rst),
      .start          (start),
      .number_samples (number_samples),
      .fifo_done      (fifo_done),
      .fifo_empty     (fifo_empty),
      .fifo_rd_ce     (fifo_rd_ce),
      .fifo_rd_data   (fifo_rd_data),
      .sample_data    (sample_data),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .busy           (busy),
      .done           (done),
      .underrun       (underrun)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr >= fifo_len);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sample i occupies stream bits 10i..10i+9, MSB-first across bytes.
   function automatic logic [9:0] model_sample(input int i);
      logic [9:0] s;
      int k;
      for (int b = 0; b < 10; b++) begin
         k = 10 * i + b;
         s[9-b] = fifo_mem[k/8][7-(k%8)];
      end
      return s;
   endfunction

   // FIFO read port: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (fifo_rd_ce) begin
         check("rd_not_empty", 64'(rd_ptr < fifo_len), 64'd1);
         fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
         rd_ce_count  <= rd_ce_count + 1;
      end
   end

   initial begin
      sample_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rcyc++;
         sample_ready = (ready_mode == 0) ? 1'b1 : ((rcyc % 3) == 0);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 64'(sample_valid), 64'd1);
            check("stall_data", 64'(sample_data), 64'(prev_data));
         end
         if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_sample: got %0h, expected none", sample_data);
            end else begin
               check("sample", 64'(sample_data), 64'(exp_q.pop_front()));
            end
            if (accepted < 16) cap[accepted] = sample_data;
            accepted++;
         end
         prev_stall = sample_valid && !sample_ready;
         prev_data  = sample_data;
      end
   end

   task automatic pulse_start(input int n);
      @(posedge clk);
      #1;
      start = 1'b1;
      number_samples = n;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_drain(input int n, input int avail, input bit delay_done,
                            input bit exp_under);
      int exp_samples, exp_reads;
      exp_reads   = exp_under ? avail : (n * 10 + 7) / 8;
      exp_samples = exp_under ? (avail * 8) / 10 : n;
      if (exp_samples > n) exp_samples = n;
      rd_ptr = 0;
      fifo_len = avail;
      rd_ce_count = 0;
      accepted = 0;
      exp_q.delete();
      for (int i = 0; i < exp_samples; i++) exp_q.push_back(model_sample(i));
      fifo_done = !delay_done;
      pulse_start(n);
      @(negedge clk);
      check("busy_after_start", 64'(busy), 64'd1);
      check("underrun_cleared", 64'(underrun), 64'd0);
      if (delay_done) begin
         repeat (20) @(negedge clk);
         check("no_rd_before_done", 64'(rd_ce_count), 64'd0);
         check("busy_waiting", 64'(busy), 64'd1);
         fifo_done = 1'b1;
      end
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (done) break;
         if (cyc == 8) fifo_done = 1'b0;
         @(negedge clk);
      end
      check("done_seen", 64'(done), 64'd1);
      check("samples_left_in_model", 64'(exp_q.size()), 64'd0);
      check("samples_accepted", 64'(accepted), 64'(exp_samples));
      check("rd_ce_count", 64'(rd_ce_count), 64'(exp_reads));
      check("underrun_flag", 64'(underrun), 64'(exp_under));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_cleared", 64'(busy), 64'd0);
      fifo_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      number_samples = '0;
      fifo_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_valid", 64'(sample_valid), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_rd_ce", 64'(fifo_rd_ce), 64'd0);
      rst = 1'b0;

      // T1: known packing vector
      fifo_mem[0] = 8'h3A; fifo_mem[1] = 8'h9E; fifo_mem[2] = 8'h2B;
      fifo_mem[3] = 8'h4C; fifo_mem[4] = 8'h7F;
      check("model_s0", 64'(model_sample(0)), 64'h0EA);
      check("model_s1", 64'(model_sample(1)), 64'h1E2);
      check("model_s2", 64'(model_sample(2)), 64'h2D3);
      check("model_s3", 64'(model_sample(3)), 64'h07F);
      ready_mode = 0;
      run_drain(4, 5, 1'b0, 1'b0);
      check("t1_s0", 64'(cap[0]), 64'h0EA);
      check("t1_s1", 64'(cap[1]), 64'h1E2);
      check("t1_s2", 64'(cap[2]), 64'h2D3);
      check("t1_s3", 64'(cap[3]), 64'h07F);

      // T2: 100 samples, 1/3-duty backpressure
      for (int i = 0; i < 256; i++) fifo_mem[i] = 8'($urandom);
      ready_mode = 1;
      run_drain(100, 125, 1'b0, 1'b0);

      // T3: 3 samples, pad bits dropped, FIFO holds more than needed
      ready_mode = 0;
      run_drain(3, 8, 1'b0, 1'b0);

      // T5: underrun after 6 bytes
      run_drain(8, 6, 1'b0, 1'b1);

      // T4: start before fifo_done; also shows underrun cleared by start
      run_drain(4, 10, 1'b1, 1'b0);

      // T6: reset mid-drain with a read in flight
      ready_mode = 1;
      rd_ptr = 0;
      fifo_len = 125;
      exp_q.delete();
      for (int i = 0; i < 100; i++) exp_q.push_back(model_sample(i));
      fifo_done = 1'b1;
      pulse_start(100);
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(negedge clk);
         if (cyc > 20 && fifo_rd_ce) break;
      end
      check("t6_rd_in_flight", 64'(fifo_rd_ce), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_valid", 64'(sample_valid), 64'd0);
      check("t6_rst_data", 64'(sample_data), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      check("t6_rst_rd_ce", 64'(fifo_rd_ce), 64'd0);
      rst = 1'b0;
      fifo_done = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("t6_idle_valid", 64'(sample_valid), 64'd0);
      rd_ce_count = 0;
      pulse_start(0);
      @(negedge clk);
      check("t6_zero_done", 64'(done), 64'd1);
      @(negedge clk);
      check("t6_zero_done_pulse", 64'(done), 64'd0);
      check("t6_zero_busy", 64'(busy), 64'd0);
      check("t6_zero_reads", 64'(rd_ce_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
